scroll_engine: RTL
==================

// Module: scroll_engine
// PURPOSE
//  Executes scroll requests from the parser's cursor/scroll logic against the text-buffer RAM.
//  Accepts one request (direction, step, region top/bottom) at a time.
//  Moves region rows by a block copy through a 1-cycle-latency RAM, then fills vacated rows with a blank cell.
//  Sits between the parser and the text RAM write port; the parser stalls on req_ready=0.
// PARAMETERS
//  COLUMNS  80  cells per line
//  LINES    50  lines on screen
//  ADDR_W   12  RAM address width; must satisfy 2**ADDR_W >= LINES*COLUMNS
//  CELL_W   32  bits per cell (char + attributes)
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       async reset, active low
//  req_valid   in   1       scroll request present
//  req_ready   out  1       1 = IDLE, request accepted when req_valid & req_ready
//  req_dir     in   1       1 = up (content moves toward line 0), 0 = down
//  req_step    in   8       lines to scroll
//  req_top     in   8       first line of region, inclusive
//  req_bottom  in   8       last line of region, inclusive
//  fill_cell   in   CELL_W  blank cell written into vacated lines
//  ram_raddr   out  ADDR_W  read address; ram_rdata is valid the following cycle
//  ram_rdata   in   CELL_W  read data
//  ram_we      out  1       write strobe
//  ram_waddr   out  ADDR_W  write address
//  ram_wdata   out  CELL_W  write data
//  busy        out  1       operation in progress (= ~req_ready)
//  done        out  1       one-cycle pulse at end of operation
// BEHAVIOUR
//  - Reset (asynchronous, rst_n low): state=IDLE, req_ready=1, busy=0, done=0, ram_we=0, all addresses/data=0.
//    A reset during any state aborts the operation; ram_we is low from reset assertion onward and a partial scroll is left.
//  - Accept: capture request and fill_cell on the accepting edge. Later input changes have no effect until the next accept.
//  - Normalise (on accept):
//    - bot = min(req_bottom, LINES-1).
//    - If req_top > bot or req_step == 0: no RAM writes; next state is DONE.
//    - H = bot-top+1; n = min(req_step, H).
//    - All address math is at least ADDR_W+1 bits wide; addr = line*COLUMNS + col.
//  - States: IDLE -> COPY -> FLUSH -> CLEAR -> DONE -> IDLE.
//    - COPY and FLUSH are skipped when n == H.
//  - COPY: one read per cycle for (H-n)*COLUMNS cycles.
//    - Each read's data is written one cycle later: ram_we=1, ram_wdata=ram_rdata, ram_waddr = that read's destination.
//    - Up: dst ascends from top*C to (bot-n+1)*C-1; src = dst + n*C.
//    - Down: dst descends from (bot+1)*C-1 to (top+n)*C; src = dst - n*C.
//    - These orders guarantee no cell is overwritten before it is read.
//  - FLUSH: one cycle; performs the final pending copy write and issues no read.
//  - CLEAR: n*COLUMNS cycles, one write per cycle, ram_wdata = captured fill_cell.
//    - Up: ascending over lines bot-n+1..bot.
//    - Down: ascending over lines top..top+n-1.
//  - DONE: done=1 and ram_we=0 for exactly one cycle; IDLE (req_ready=1) follows.
//  - Latency: done rises (H-n)*C + (n<H ? 1 : 0) + n*C + 1 cycles after the accepting edge.
//    Degenerate requests take 1 cycle.
//  - ram_we is never asserted outside COPY(+1)/FLUSH/CLEAR.
//  - Lines outside [top, bot] are never written.
//  - req_valid while busy is ignored; the requester holds it. A back-to-back request is accepted in the first IDLE cycle after DONE.
// TESTING
//  - Setup: C=80, L=50; preload cell(line, col) = {line, col}.
//  - Up 0..49, step 1 -> line i = old i+1 (i<49), line 49 = fill; done 4002 cycles after accept.
//  - Down top=10, bot=19, step=3 -> lines 13..19 = old 10..16, 10..12 = fill; lines 0-9 and 20-49 unchanged (write monitor).
//  - step=0 -> zero writes, done next cycle.
//  - top=5, bot=9, step=200 -> n=5, lines 5..9 = fill, no reads, 400 writes.
//  - top=30, bot=20 -> zero writes, done next cycle.
//  - bot=70, top=48, step=1 up -> line 48 = old 49, line 49 = fill; no address >= 4000.
//  - req_valid held high across two requests -> second accepted the cycle after done.
//  - fill_cell toggled mid-CLEAR -> fill values unaffected.
//  - rst_n low mid-COPY -> ram_we=0 immediately, req_ready=1; a new request runs correctly.

Source files
------------

// File: rtl/scroll_engine_if.sv
// rtl/scroll_engine_if.sv - request, RAM-port and status bundle for scroll_engine
interface scroll_engine_if #(
    parameter int ADDR_W = 12,
    parameter int CELL_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_dir;
    logic [7:0]        req_step;
    logic [7:0]        req_top;
    logic [7:0]        req_bottom;
    logic [CELL_W-1:0] fill_cell;
    logic [ADDR_W-1:0] ram_raddr;
    logic [CELL_W-1:0] ram_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [CELL_W-1:0] ram_wdata;
    logic              busy;
    logic              done;

    // Parser plus text RAM side
    modport master (
        output req_valid, req_dir, req_step, req_top, req_bottom, fill_cell, ram_rdata,
        input  req_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, busy, done
    );

    // Scroll engine side
    modport slave (
        input  req_valid, req_dir, req_step, req_top, req_bottom, fill_cell, ram_rdata,
        output req_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, busy, done
    );
endinterface

// File: rtl/scroll_engine.sv
// rtl/scroll_engine.sv - region scroll by block copy then blank fill on the text RAM
module scroll_engine #(
    parameter int COLUMNS = 80,
    parameter int LINES   = 50,
    parameter int ADDR_W  = 12,
    parameter int CELL_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    scroll_engine_if.slave   bus
);
    // Address math runs wider than the RAM address so intermediates never wrap
    localparam int MW = ADDR_W + 4;
    localparam int CW = MW;

    typedef enum logic [2:0] {IDLE, COPY, FLUSH, CLEAR, DONE} state_t;

    state_t              state_q;
    logic                dir_q;
    logic [CELL_W-1:0]   fill_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       clr_cnt_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [ADDR_W-1:0]   pend_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic                we_q;
    logic                wsel_q;
    logic                done_q;

    logic [7:0]          bot_d;
    logic [7:0]          h_d;
    logic [7:0]          n_d;
    logic                degen_d;
    logic [MW-1:0]       top_w;
    logic [MW-1:0]       bot_w;
    logic [MW-1:0]       col_w;
    logic [MW-1:0]       ncol_w;
    logic [ADDR_W-1:0]   dst0_d;
    logic [ADDR_W-1:0]   src0_d;
    logic [ADDR_W-1:0]   clr0_d;
    logic [CW-1:0]       copy_cnt_d;
    logic [CW-1:0]       clr_cnt_d;

    // Normalise the incoming request: clip region, clamp step, derive start addresses and counts
    always_comb begin
        bot_d   = (bus.req_bottom > 8'(LINES - 1)) ? 8'(LINES - 1) : bus.req_bottom;
        degen_d = (bus.req_top > bot_d) || (bus.req_step == 8'd0);
        h_d     = bot_d - bus.req_top + 8'd1;
        n_d     = (bus.req_step < h_d) ? bus.req_step : h_d;
        top_w   = MW'(bus.req_top);
        bot_w   = MW'(bot_d);
        col_w   = MW'(COLUMNS);
        ncol_w  = MW'(n_d) * col_w;
        if (bus.req_dir) begin
            dst0_d = ADDR_W'(top_w * col_w);
            src0_d = ADDR_W'(top_w * col_w + ncol_w);
            clr0_d = ADDR_W'((bot_w - MW'(n_d) + MW'(1)) * col_w);
        end else begin
            dst0_d = ADDR_W'((bot_w + MW'(1)) * col_w - MW'(1));
            src0_d = ADDR_W'((bot_w + MW'(1)) * col_w - MW'(1) - ncol_w);
            clr0_d = ADDR_W'(top_w * col_w);
        end
        copy_cnt_d = CW'(MW'(h_d - n_d) * col_w);
        clr_cnt_d  = CW'(ncol_w);
    end

    // Control FSM: COPY writes lag reads by one cycle, FLUSH retires the last copy write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            fill_q     <= '0;
            cnt_q      <= '0;
            clr_cnt_q  <= '0;
            clr_addr_q <= '0;
            raddr_q    <= '0;
            pend_q     <= '0;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            wsel_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    if (bus.req_valid) begin
                        dir_q      <= bus.req_dir;
                        fill_q     <= bus.fill_cell;
                        clr_addr_q <= clr0_d;
                        clr_cnt_q  <= clr_cnt_d;
                        if (degen_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (copy_cnt_d == '0) begin
                            state_q <= CLEAR;
                            we_q    <= 1'b1;
                            wsel_q  <= 1'b0;
                            waddr_q <= clr0_d;
                            cnt_q   <= clr_cnt_d - 1'b1;
                        end else begin
                            state_q <= COPY;
                            raddr_q <= src0_d;
                            pend_q  <= dst0_d;
                            cnt_q   <= copy_cnt_d - 1'b1;
                        end
                    end
                end
                COPY: begin
                    we_q    <= 1'b1;
                    wsel_q  <= 1'b1;
                    waddr_q <= pend_q;
                    if (cnt_q == '0) begin
                        state_q <= FLUSH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (dir_q) begin
                            raddr_q <= raddr_q + 1'b1;
                            pend_q  <= pend_q + 1'b1;
                        end else begin
                            raddr_q <= raddr_q - 1'b1;
                            pend_q  <= pend_q - 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= CLEAR;
                    we_q    <= 1'b1;
                    wsel_q  <= 1'b0;
                    waddr_q <= clr_addr_q;
                    cnt_q   <= clr_cnt_q - 1'b1;
                end
                CLEAR: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        waddr_q <= waddr_q + 1'b1;
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.ram_raddr = raddr_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wsel_q ? bus.ram_rdata : fill_q;
endmodule
